mul_div_iter: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU operand converter. It accepts operand magnitudes plus "was negated" flags and runs a 32-step shift-add multiply or restoring divide. It re-applies sign to the result and returns a 32-bit result with a start/done handshake. The ALU stalls on `busy_o` while an M-extension operation is in flight.

---
 rtl/md_pkg.sv | 37 +++
 rtl/mul_div_iter_if.sv | 30 +++
 rtl/md_addsub.sv | 20 ++
 rtl/mul_div_iter.sv | 166 ++++++++++++++++
 tb/tb_mul_div_iter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Optional build macro MD_DIV0_FAST_EN is consumed by mul_div_iter.sv.
package md_pkg;

  // M-extension operation codes, in funct3 order
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_t;

  // FSM state encoding, exported through the bus for observation
  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_CALC = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;
  localparam md_state_t ST_DONE = 2'd3;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

  // Step counter width for an arbitrary operand width
  function automatic int md_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Upper half of the op code selects the divide family
  function automatic logic md_is_div(input md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/mul_div_iter_if.sv
// ALU <-> multiply/divide unit bus.
// Handshake: start_i is sampled only while busy_o is low and flush_i is low;
// the operand fields are only meaningful in that cycle. The unit answers with
// a single-cycle done_o pulse, and result_o stays valid until the next
// accepted start. flush_i aborts an operation in flight without a done_o.
interface mul_div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 flush_i;
  md_pkg::md_op_t       op_i;
  logic [WIDTH-1:0]     operator_1_c;
  logic [WIDTH-1:0]     operator_2_c;
  logic                 neg_1;
  logic                 neg_2;
  logic                 busy_o;
  logic                 done_o;
  logic [WIDTH-1:0]     result_o;
  md_pkg::md_state_t    state;

  modport master (
    output start_i, flush_i, op_i, operator_1_c, operator_2_c, neg_1, neg_2,
    input  busy_o, done_o, result_o, state
  );

  modport slave (
    input  start_i, flush_i, op_i, operator_1_c, operator_2_c, neg_1, neg_2,
    output busy_o, done_o, result_o, state
  );
endinterface

// File: rtl/md_addsub.sv
// Adder/subtractor with borrow-out, shared by the multiply accumulate step
// and the divide trial subtraction.
module md_addsub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             borrow
);
  logic [WIDTH:0] full;

  // One extra bit catches the borrow of a - b
  always_comb begin
    full   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    sum    = full[WIDTH-1:0];
    borrow = sub & full[WIDTH];
  end
endmodule

// File: rtl/mul_div_iter.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring
// divide on operand magnitudes, sign re-applied in a FIX cycle.
// Build macro MD_DIV0_FAST_EN: when defined, a divide by zero jumps from IDLE
// straight to FIX with the restoring-division result preloaded.
module mul_div_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mul_div_iter_if.slave  bus
);
  localparam int CNT_W = md_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  hi_q;      // product high half / partial remainder
  logic [WIDTH-1:0]  lo_q;      // multiplier being consumed / quotient
  logic [WIDTH-1:0]  opa_q;     // multiplicand
  logic [WIDTH-1:0]  opb_q;     // divisor
  md_op_t            op_q;
  logic              neg1_q;
  logic              neg2_q;
  logic              div0_q;
  logic [WIDTH-1:0]  result_q;
  logic              done_q;

  logic [WIDTH:0]    as_a;
  logic [WIDTH:0]    as_b;
  logic              as_sub;
  logic [WIDTH:0]    as_sum;
  logic              as_borrow;
  logic [WIDTH-1:0]  hi_nxt;
  logic [WIDTH-1:0]  lo_nxt;
  logic [WIDTH-1:0]  fix_result;

  md_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
    .a      (as_a),
    .b      (as_b),
    .sub    (as_sub),
    .sum    (as_sum),
    .borrow (as_borrow)
  );

  // Operand steering into the shared adder for the current step
  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    if (md_is_div(op_q)) begin
      as_a   = {hi_q, lo_q[WIDTH-1]};
      as_b   = {1'b0, opb_q};
      as_sub = 1'b1;
    end else begin
      as_a   = {1'b0, hi_q};
      as_b   = lo_q[0] ? {1'b0, opa_q} : '0;
      as_sub = 1'b0;
    end
  end

  // Next accumulator value after one multiply or divide step
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (md_is_div(op_q)) begin
      hi_nxt = as_borrow ? as_a[WIDTH-1:0] : as_sum[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], ~as_borrow};
    end else begin
      hi_nxt = as_sum[WIDTH:1];
      lo_nxt = {as_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and output selection; the divide-by-zero quotient keeps
  // its all-ones value regardless of operand signs
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    prod       = {hi_q, lo_q};
    prod_s     = (neg1_q ^ neg2_q) ? -prod : prod;
    quot_s     = ((neg1_q ^ neg2_q) && !div0_q) ? -lo_q : lo_q;
    rem_s      = neg1_q ? -hi_q : hi_q;
    fix_result = '0;
    case (op_q)
      MUL:                 fix_result = prod_s[WIDTH-1:0];
      MULH, MULHSU, MULHU: fix_result = prod_s[2*WIDTH-1:WIDTH];
      DIV, DIVU:           fix_result = quot_s;
      default:             fix_result = rem_s;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= MUL;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            opa_q  <= bus.operator_1_c;
            opb_q  <= bus.operator_2_c;
            op_q   <= bus.op_i;
            neg1_q <= bus.neg_1;
            neg2_q <= bus.neg_2;
            div0_q <= (bus.operator_2_c == '0);
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= md_is_div(bus.op_i) ? bus.operator_1_c : bus.operator_2_c;
            state_q <= ST_CALC;
`ifdef MD_DIV0_FAST_EN
            // Preload what the restoring divider would converge to
            if (md_is_div(bus.op_i) && (bus.operator_2_c == '0)) begin
              hi_q    <= bus.operator_1_c;
              lo_q    <= '1;
              state_q <= ST_FIX;
            end
`endif
          end
        end
        ST_CALC: begin
          if (bus.flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (bus.flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mul_div_iter.sv
// Directed self-checking bench for mul_div_iter.
// Latency is counted in rising edges from the accepting edge (inclusive) to
// the edge after which done_o is seen: 34 for the full path, 2 for the
// divide-by-zero shortcut built with MD_DIV0_FAST_EN.
module tb_mul_div_iter;
  import md_pkg::*;

  localparam int W           = 32;
  localparam int LAT_FULL    = 34;
  localparam int LAT_TIMEOUT = 100;
`ifdef MD_DIV0_FAST_EN
  localparam int LAT_DIV0 = 2;
`else
  localparam int LAT_DIV0 = 34;
`endif

  typedef struct {
    md_op_t       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         n1;
    logic         n2;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_div_iter_if #(.WIDTH(W)) bus();

  mul_div_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.op_i         = MUL;
    bus.operator_1_c = '0;
    bus.operator_2_c = '0;
    bus.neg_1        = 1'b0;
    bus.neg_2        = 1'b0;
  endtask

  // Present one operation for a single edge, then scramble the don't-care inputs
  task automatic issue(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic n1, input logic n2);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy_o && guard < LAT_TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    bus.op_i         = op;
    bus.operator_1_c = a;
    bus.operator_2_c = b;
    bus.neg_1        = n1;
    bus.neg_2        = n2;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i      = 1'b0;
    bus.op_i         = md_op_t'($urandom_range(0, 7));
    bus.operator_1_c = $urandom;
    bus.operator_2_c = $urandom;
    bus.neg_1        = 1'($urandom_range(0, 1));
    bus.neg_2        = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done_o; called right after issue()
  task automatic wait_done(output logic [W-1:0] res, output int lat, output logic to);
    lat = 1;
    while (!bus.done_o && lat < LAT_TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    to  = !bus.done_o;
    res = bus.result_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", bus.result_o); end
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    vec_t v[5];
    logic [W-1:0] res;
    int lat;
    logic to;
    v[0] = '{MUL,    32'd7,          32'd3,          1'b0, 1'b1, 32'hFFFF_FFEB};
    v[1] = '{MULH,   32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 32'h4000_0000};
    v[2] = '{MULHU,  32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, 32'h4000_0000};
    v[3] = '{MULHSU, 32'd1,          32'hFFFF_FFFF,  1'b1, 1'b0, 32'hFFFF_FFFF};
    v[4] = '{MUL,    32'h1234_5678,  32'h0000_0010,  1'b0, 1'b0, 32'h2345_6780};
    for (int i = 0; i < 5; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].n1, v[i].n2);
      wait_done(res, lat, to);
      checks++;
      if (to || res !== v[i].exp) begin
        errors++;
        $display("FAIL mul_result[%0d] op=%0d: got %h want %h (timeout=%b)", i, v[i].op, res, v[i].exp, to);
      end
      checks++;
      if (lat != LAT_FULL) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, LAT_FULL);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[8];
    logic [W-1:0] res;
    int lat;
    logic to;
    v[0] = '{DIV,  32'd7,         32'd2,  1'b1, 1'b0, 32'hFFFF_FFFD};
    v[1] = '{REM,  32'd7,         32'd2,  1'b1, 1'b0, 32'hFFFF_FFFF};
    v[2] = '{DIV,  32'h8000_0000, 32'd1,  1'b1, 1'b1, 32'h8000_0000};
    v[3] = '{REM,  32'h8000_0000, 32'd1,  1'b1, 1'b1, 32'h0000_0000};
    v[4] = '{DIVU, 32'd100,       32'd7,  1'b0, 1'b0, 32'd14};
    v[5] = '{REMU, 32'd100,       32'd7,  1'b0, 1'b0, 32'd2};
    v[6] = '{DIV,  32'd20,        32'd3,  1'b0, 1'b1, 32'hFFFF_FFFA};
    v[7] = '{REM,  32'd20,        32'd3,  1'b0, 1'b1, 32'd2};
    for (int i = 0; i < 8; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].n1, v[i].n2);
      wait_done(res, lat, to);
      checks++;
      if (to || res !== v[i].exp) begin
        errors++;
        $display("FAIL div_result[%0d] op=%0d: got %h want %h (timeout=%b)", i, v[i].op, res, v[i].exp, to);
      end
      checks++;
      if (lat != LAT_FULL) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, LAT_FULL);
      end
    end
  endtask

  task automatic test_div0();
    vec_t v[4];
    logic [W-1:0] res;
    int lat;
    logic to;
    v[0] = '{DIV,  32'd5,    32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF};
    v[1] = '{REM,  32'd5,    32'd0, 1'b1, 1'b0, 32'hFFFF_FFFB};
    v[2] = '{DIVU, 32'd1234, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF};
    v[3] = '{REMU, 32'd1234, 32'd0, 1'b0, 1'b0, 32'd1234};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].n1, v[i].n2);
      wait_done(res, lat, to);
      checks++;
      if (to || res !== v[i].exp) begin
        errors++;
        $display("FAIL div0_result[%0d] op=%0d: got %h want %h (timeout=%b)", i, v[i].op, res, v[i].exp, to);
      end
      checks++;
      if (lat != LAT_DIV0) begin
        errors++;
        $display("FAIL div0_latency[%0d]: got %0d want %0d", i, lat, LAT_DIV0);
      end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] res;
    int lat;
    logic to;
    issue(DIVU, 32'd50, 32'd5, 1'b0, 1'b0);
    wait_done(res, lat, to);
    checks++; if (to || res !== 32'd10) begin errors++; $display("FAIL flush_pre_result: got %h want 0000000a", res); end
    issue(DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b want 1", bus.busy_o); end
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", bus.done_o); end
    checks++; if (bus.result_o !== 32'd10) begin errors++; $display("FAIL flush_result_held: got %h want 0000000a", bus.result_o); end
    issue(DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(res, lat, to);
    checks++; if (to || res !== 32'd14) begin errors++; $display("FAIL flush_next_result: got %h want 0000000e", res); end
    checks++; if (lat != LAT_FULL) begin errors++; $display("FAIL flush_next_latency: got %0d want %0d", lat, LAT_FULL); end
  endtask

  task automatic test_start_busy();
    logic [W-1:0] res;
    int lat;
    logic to;
    int extra;
    issue(MUL, 32'd6, 32'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.op_i         = DIVU;
    bus.operator_1_c = 32'd9;
    bus.operator_2_c = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_done(res, lat, to);
    checks++; if (to || res !== 32'd42) begin errors++; $display("FAIL busy_start_result: got %h want 0000002a", res); end
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_start_extra_done: got %0d want 0", extra); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_reset_mid();
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", bus.done_o); end
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 00000000", bus.result_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res;
    int lat;
    logic to;
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(res, lat, to);
    checks++; if (to || res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_first: got %h want fffffffe", res); end
    issue(DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0);
    wait_done(res, lat, to);
    checks++; if (to || res !== 32'h1999_9999) begin errors++; $display("FAIL b2b_second: got %h want 19999999", res); end
    checks++; if (lat != LAT_FULL) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_FULL); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_flush();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
